// File: rtl/unstriping_if.sv
// Lane-side and merged-stream signals of the two-lane unstriper.
//   master : the receive front end (drives lane_0/lane_1 and their valids,
//            observes the merged stream and status)
//   slave  : the unstriper itself
// Ports (all on clk_2f):
//   lane_0/valid_0   even stream positions
//   lane_1/valid_1   odd stream positions
//   data_out/valid_out merged, registered output word
//   sel              lane expected next (0 = lane_0)
//   fill_0/fill_1    per-lane FIFO occupancy
//   overflow_0/_1    sticky word-dropped flags
interface unstriping_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
);
    logic [DATA_W-1:0] lane_0;
    logic              valid_0;
    logic [DATA_W-1:0] lane_1;
    logic              valid_1;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              sel;
    logic [ADDR_W:0]   fill_0;
    logic [ADDR_W:0]   fill_1;
    logic              overflow_0;
    logic              overflow_1;

    modport master (
        output lane_0, valid_0, lane_1, valid_1,
        input  data_out, valid_out, sel, fill_0, fill_1, overflow_0, overflow_1
    );

    modport slave (
        input  lane_0, valid_0, lane_1, valid_1,
        output data_out, valid_out, sel, fill_0, fill_1, overflow_0, overflow_1
    );
endinterface

// File: rtl/unstriping.sv
// Two-lane unstriper: re-merges words striped across lane_0 (even positions)
// and lane_1 (odd positions) into one ordered stream. Each lane is buffered
// in a small FIFO so skew and bursts are absorbed; the read side strictly
// alternates lanes starting with lane_0 and stalls rather than skipping.
// Ports:
//   clk_2f  single clock, rising edge
//   reset   synchronous, active-high; flushes both FIFOs and clears flags
//   bus     unstriping_if.slave (lane inputs, merged output, status)
module unstriping #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic         clk_2f,
    input  logic         reset,
    unstriping_if.slave  bus
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

    // Lane FIFO storage. Not reset: pointers and counts define validity.
    logic [DATA_W-1:0] mem_0_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_1_q [FIFO_DEPTH];

    logic [ADDR_W-1:0] wr_ptr_0_q, wr_ptr_0_d;
    logic [ADDR_W-1:0] rd_ptr_0_q, rd_ptr_0_d;
    logic [ADDR_W-1:0] wr_ptr_1_q, wr_ptr_1_d;
    logic [ADDR_W-1:0] rd_ptr_1_q, rd_ptr_1_d;
    logic [ADDR_W:0]   fill_0_q, fill_0_d;
    logic [ADDR_W:0]   fill_1_q, fill_1_d;
    logic              ovf_0_q, ovf_0_d;
    logic              ovf_1_q, ovf_1_d;
    logic              sel_q, sel_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;

    logic pop_0, pop_1;
    logic push_0, push_1;

    // Pops look only at registered occupancy, so a word written this edge
    // cannot be read until the next one (no write-to-read bypass).
    always_comb begin
        pop_0 = (sel_q == 1'b0) && (fill_0_q != '0);
        pop_1 = (sel_q == 1'b1) && (fill_1_q != '0);
    end

    // A full FIFO being popped this cycle still has room for the write.
    always_comb begin
        push_0 = bus.valid_0 && ((fill_0_q != FULL_CNT) || pop_0);
        push_1 = bus.valid_1 && ((fill_1_q != FULL_CNT) || pop_1);
    end

    always_comb begin
        wr_ptr_0_d = wr_ptr_0_q;
        rd_ptr_0_d = rd_ptr_0_q;
        fill_0_d   = fill_0_q;
        ovf_0_d    = ovf_0_q;

        if (push_0) begin
            wr_ptr_0_d = wr_ptr_0_q + PTR_ONE;
        end
        if (pop_0) begin
            rd_ptr_0_d = rd_ptr_0_q + PTR_ONE;
        end
        if (push_0 && !pop_0) begin
            fill_0_d = fill_0_q + CNT_ONE;
        end else if (pop_0 && !push_0) begin
            fill_0_d = fill_0_q - CNT_ONE;
        end
        if (bus.valid_0 && !push_0) begin
            ovf_0_d = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_1_d = wr_ptr_1_q;
        rd_ptr_1_d = rd_ptr_1_q;
        fill_1_d   = fill_1_q;
        ovf_1_d    = ovf_1_q;

        if (push_1) begin
            wr_ptr_1_d = wr_ptr_1_q + PTR_ONE;
        end
        if (pop_1) begin
            rd_ptr_1_d = rd_ptr_1_q + PTR_ONE;
        end
        if (push_1 && !pop_1) begin
            fill_1_d = fill_1_q + CNT_ONE;
        end else if (pop_1 && !push_1) begin
            fill_1_d = fill_1_q - CNT_ONE;
        end
        if (bus.valid_1 && !push_1) begin
            ovf_1_d = 1'b1;
        end
    end

    // Merge: only the lane named by sel may be read; if it is empty the
    // output idles even when the other lane has data, keeping stream order.
    always_comb begin
        data_out_d  = '0;
        valid_out_d = 1'b0;
        sel_d       = sel_q;

        if (pop_0) begin
            data_out_d  = mem_0_q[rd_ptr_0_q];
            valid_out_d = 1'b1;
            sel_d       = 1'b1;
        end else if (pop_1) begin
            data_out_d  = mem_1_q[rd_ptr_1_q];
            valid_out_d = 1'b1;
            sel_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (push_0) begin
            mem_0_q[wr_ptr_0_q] <= bus.lane_0;
        end
        if (push_1) begin
            mem_1_q[wr_ptr_1_q] <= bus.lane_1;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            wr_ptr_0_q  <= '0;
            rd_ptr_0_q  <= '0;
            wr_ptr_1_q  <= '0;
            rd_ptr_1_q  <= '0;
            fill_0_q    <= '0;
            fill_1_q    <= '0;
            ovf_0_q     <= 1'b0;
            ovf_1_q     <= 1'b0;
            sel_q       <= 1'b0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            wr_ptr_0_q  <= wr_ptr_0_d;
            rd_ptr_0_q  <= rd_ptr_0_d;
            wr_ptr_1_q  <= wr_ptr_1_d;
            rd_ptr_1_q  <= rd_ptr_1_d;
            fill_0_q    <= fill_0_d;
            fill_1_q    <= fill_1_d;
            ovf_0_q     <= ovf_0_d;
            ovf_1_q     <= ovf_1_d;
            sel_q       <= sel_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.sel        = sel_q;
    assign bus.fill_0     = fill_0_q;
    assign bus.fill_1     = fill_1_q;
    assign bus.overflow_0 = ovf_0_q;
    assign bus.overflow_1 = ovf_1_q;

endmodule

// File: tb/tb_unstriping.sv
// Bench for the two-lane unstriper. Expected merged words are queued in
// stream order as stimulus is driven; a negedge monitor pops and compares
// every valid output and checks that idle cycles carry zero data.
module tb_unstriping;

    logic clk_2f = 1'b0;
    logic reset  = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic [31:0] exp_q [$];

    always #5 clk_2f = ~clk_2f;

    unstriping_if #(.DATA_W(32), .ADDR_W(2)) bus ();

    unstriping #(.DATA_W(32), .FIFO_DEPTH(4), .ADDR_W(2)) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus)
    );

    always @(negedge clk_2f) begin
        if (mon_en) begin
            checks++;
            if (bus.valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word got %h expected no output", bus.data_out);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (bus.data_out !== e) begin
                        errors++;
                        $display("FAIL stream_word got %h expected %h", bus.data_out, e);
                    end
                end
            end else if (bus.valid_out !== 1'b0 || bus.data_out !== 32'h0) begin
                errors++;
                $display("FAIL idle_output got valid %b data %h expected 0/0",
                         bus.valid_out, bus.data_out);
            end
        end
    end

    task automatic step();
        @(posedge clk_2f);
        #1;
    endtask

    task automatic idle(input int n);
        bus.valid_0 = 1'b0;
        bus.valid_1 = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        bus.lane_0  = 32'h12345678;
        bus.lane_1  = 32'h9abcdef0;
        bus.valid_0 = 1'b1;
        bus.valid_1 = 1'b1;
        reset = 1'b1;
        step();
        step();
        checks++;
        if (bus.data_out !== 32'h0 || bus.valid_out !== 1'b0 || bus.sel !== 1'b0 ||
            bus.fill_0 !== 3'd0 || bus.fill_1 !== 3'd0 ||
            bus.overflow_0 !== 1'b0 || bus.overflow_1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got data %h vout %b sel %b f0 %0d f1 %0d ov %b%b expected all zero",
                     bus.data_out, bus.valid_out, bus.sel, bus.fill_0, bus.fill_1,
                     bus.overflow_0, bus.overflow_1);
        end
        bus.valid_0 = 1'b0;
        bus.valid_1 = 1'b0;
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_striped_burst();
        bus.lane_0 = 32'hFFFFFFFF; bus.valid_0 = 1'b1; exp_q.push_back(32'hFFFFFFFF);
        step();
        bus.valid_0 = 1'b0;
        bus.lane_1 = 32'hEEEEEEEE; bus.valid_1 = 1'b1; exp_q.push_back(32'hEEEEEEEE);
        step();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL striped_latency got %b/%h expected 1/ffffffff", bus.valid_out, bus.data_out);
        end
        bus.valid_1 = 1'b0;
        bus.lane_0 = 32'hDDDDDDDD; bus.valid_0 = 1'b1; exp_q.push_back(32'hDDDDDDDD);
        step();
        bus.valid_0 = 1'b0;
        bus.lane_1 = 32'hCCCCCCCC; bus.valid_1 = 1'b1; exp_q.push_back(32'hCCCCCCCC);
        step();
        bus.valid_1 = 1'b0;
        step();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 32'hCCCCCCCC) begin
            errors++;
            $display("FAIL striped_last got %b/%h expected 1/cccccccc", bus.valid_out, bus.data_out);
        end
        step();
        checks++;
        if (bus.valid_out !== 1'b0 || bus.sel !== 1'b0 || bus.fill_0 !== 3'd0 || bus.fill_1 !== 3'd0) begin
            errors++;
            $display("FAIL striped_drain got vout %b sel %b f0 %0d f1 %0d expected 0 0 0 0",
                     bus.valid_out, bus.sel, bus.fill_0, bus.fill_1);
        end
    endtask

    task automatic test_skew_stall();
        bus.lane_1 = 32'h00000004; bus.valid_1 = 1'b1;
        exp_q.push_back(32'h00000003);
        exp_q.push_back(32'h00000004);
        step();
        bus.valid_1 = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL skew_stall_c1 got vout %b expected 0", bus.valid_out);
        end
        step();
        bus.lane_0 = 32'h00000003; bus.valid_0 = 1'b1;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.fill_1 !== 3'd1) begin
            errors++;
            $display("FAIL skew_stall_c2 got vout %b f1 %0d expected 0 1", bus.valid_out, bus.fill_1);
        end
        step();
        bus.valid_0 = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.fill_1 !== 3'd1 || bus.fill_0 !== 3'd1) begin
            errors++;
            $display("FAIL skew_stall_c3 got vout %b f0 %0d f1 %0d expected 0 1 1",
                     bus.valid_out, bus.fill_0, bus.fill_1);
        end
        step();
        checks++;
        if (bus.data_out !== 32'h00000003 || bus.fill_1 !== 3'd1 || bus.sel !== 1'b1) begin
            errors++;
            $display("FAIL skew_c4 got %h f1 %0d sel %b expected 00000003 1 1",
                     bus.data_out, bus.fill_1, bus.sel);
        end
        step();
        checks++;
        if (bus.data_out !== 32'h00000004 || bus.fill_1 !== 3'd0 || bus.sel !== 1'b0) begin
            errors++;
            $display("FAIL skew_c5 got %h f1 %0d sel %b expected 00000004 0 0",
                     bus.data_out, bus.fill_1, bus.sel);
        end
        idle(2);
    endtask

    task automatic test_simultaneous();
        bus.lane_0 = 32'h00000200; bus.valid_0 = 1'b1;
        bus.lane_1 = 32'h00000005; bus.valid_1 = 1'b1;
        exp_q.push_back(32'h00000200);
        exp_q.push_back(32'h00000005);
        step();
        bus.valid_0 = 1'b0;
        bus.valid_1 = 1'b0;
        checks++;
        if (bus.fill_0 !== 3'd1 || bus.fill_1 !== 3'd1) begin
            errors++;
            $display("FAIL simul_fill got f0 %0d f1 %0d expected 1 1", bus.fill_0, bus.fill_1);
        end
        step();
        step();
        checks++;
        if (bus.data_out !== 32'h00000005 || bus.overflow_0 !== 1'b0 || bus.overflow_1 !== 1'b0) begin
            errors++;
            $display("FAIL simul_second got %h ov %b%b expected 00000005 00",
                     bus.data_out, bus.overflow_0, bus.overflow_1);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] w;
            w = $urandom;
            bus.valid_0 = (i % 2 == 0);
            bus.valid_1 = (i % 2 == 1);
            if (i % 2 == 0) bus.lane_0 = w;
            else            bus.lane_1 = w;
            exp_q.push_back(w);
            step();
            if (i >= 2) begin
                checks++;
                if (bus.valid_out !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_throughput word %0d got vout %b expected 1", i, bus.valid_out);
                end
            end
        end
        idle(3);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 6; i++) begin
            bus.lane_0  = 32'hAAAAAAA0 + 32'(i);
            bus.valid_0 = 1'b1;
            if (i == 1) exp_q.push_back(32'hAAAAAAA1);
            step();
            if (i == 5) begin
                checks++;
                if (bus.fill_0 !== 3'd4 || bus.overflow_0 !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full got f0 %0d ov0 %b expected 4 0", bus.fill_0, bus.overflow_0);
                end
            end
        end
        bus.valid_0 = 1'b0;
        checks++;
        if (bus.fill_0 !== 3'd4 || bus.overflow_0 !== 1'b1 || bus.sel !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop got f0 %0d ov0 %b sel %b expected 4 1 1",
                     bus.fill_0, bus.overflow_0, bus.sel);
        end
        step();
        bus.lane_1 = 32'hBBBBBBBB; bus.valid_1 = 1'b1;
        exp_q.push_back(32'hBBBBBBBB);
        exp_q.push_back(32'hAAAAAAA2);
        step();
        bus.valid_1 = 1'b0;
        step();
        step();
        step();
        checks++;
        if (bus.valid_out !== 1'b0 || bus.sel !== 1'b1 || bus.fill_0 !== 3'd3 ||
            bus.overflow_0 !== 1'b1 || bus.overflow_1 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_after got vout %b sel %b f0 %0d ov %b%b expected 0 1 3 10",
                     bus.valid_out, bus.sel, bus.fill_0, bus.overflow_0, bus.overflow_1);
        end
    endtask

    task automatic test_reset_midstream();
        checks++;
        if (bus.fill_0 !== 3'd3) begin
            errors++;
            $display("FAIL mid_pre got f0 %0d expected 3", bus.fill_0);
        end
        bus.lane_0 = 32'h55555555; bus.valid_0 = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.valid_0 = 1'b0;
        checks++;
        if (bus.fill_0 !== 3'd0 || bus.fill_1 !== 3'd0 || bus.overflow_0 !== 1'b0 ||
            bus.overflow_1 !== 1'b0 || bus.sel !== 1'b0 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got f0 %0d f1 %0d ov %b%b sel %b vout %b expected all 0",
                     bus.fill_0, bus.fill_1, bus.overflow_0, bus.overflow_1, bus.sel, bus.valid_out);
        end
        bus.lane_1 = 32'h11111111; bus.valid_1 = 1'b1;
        exp_q.push_back(32'h22222222);
        exp_q.push_back(32'h11111111);
        step();
        bus.valid_1 = 1'b0;
        bus.lane_0 = 32'h22222222; bus.valid_0 = 1'b1;
        step();
        bus.valid_0 = 1'b0;
        step();
        checks++;
        if (bus.data_out !== 32'h22222222) begin
            errors++;
            $display("FAIL mid_first got %h expected 22222222", bus.data_out);
        end
        step();
        step();
        checks++;
        if (bus.fill_0 !== 3'd0 || bus.fill_1 !== 3'd0 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_drain got f0 %0d f1 %0d vout %b expected 0 0 0",
                     bus.fill_0, bus.fill_1, bus.valid_out);
        end
    endtask

    initial begin
        bus.lane_0  = '0;
        bus.lane_1  = '0;
        bus.valid_0 = 1'b0;
        bus.valid_1 = 1'b0;
        test_reset();
        test_striped_burst();
        test_skew_stall();
        test_simultaneous();
        test_back_to_back();
        test_overflow();
        test_reset_midstream();
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d words pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
